md_ctrl: RTL

MD_CTRL -- requirements
Module: md_ctrl

---
 rtl/md_ctrl_pkg.sv | 24 ++
 rtl/md_ctrl.sv | 74 +++++++
 2 files changed

// File: rtl/md_ctrl_pkg.sv
// md_ctrl_pkg: shared mdOp encodings, FSM state type and op-class helpers for md_ctrl.
package md_ctrl_pkg;
  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;
  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  typedef enum logic {IDLE, BUSY} state_t;

  function automatic logic is_arith(input logic [3:0] op);
    return op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return op == MD_DIV || op == MD_DIVU;
  endfunction
endpackage

// File: rtl/md_ctrl.sv
// md_ctrl: multi-cycle multiply/divide unit owning HI/LO, with busy/stall handshake to the pipeline.
module md_ctrl
  import md_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdOp,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        dIsMd,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdRes
);
  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [31:0] a, b, a_nx, b_nx, hi_nx, lo_nx, bs, q_s, r_s, q_u, r_u;
  logic        is_div, is_sgn, is_div_nx, is_sgn_nx, launch, done, ovf, wr_res;
  logic [63:0] prod_s, prod_u, res;

  // Guard the divisor so the datapath never divides by zero; the result is discarded anyway.
  assign bs     = b == 32'd0 ? 32'd1 : b;
  assign ovf    = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  assign q_s    = ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(bs));
  assign r_s    = ovf ? 32'd0 : 32'($signed(a) % $signed(bs));
  assign q_u    = a / bs;
  assign r_u    = a % bs;
  assign prod_s = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
  assign prod_u = {32'd0, a} * {32'd0, b};
  assign res    = is_div ? (is_sgn ? {r_s, q_s} : {r_u, q_u}) : (is_sgn ? prod_s : prod_u);

  assign busy  = state == BUSY;
  assign stall = dIsMd & (busy | (start & is_arith(mdOp)));
  assign mdRes = mdOp == MD_MFHI ? hi : mdOp == MD_MFLO ? lo : 32'd0;

  always_comb begin
    launch    = state == IDLE && start && is_arith(mdOp);
    done      = state == BUSY && cnt == 4'd1;
    wr_res    = done && !(is_div && b == 32'd0);
    state_nx  = launch ? BUSY : done ? IDLE : state;
    cnt_nx    = launch ? (is_div_op(mdOp) ? DIV_CYCLES : MULT_CYCLES) : busy ? cnt - 4'd1 : cnt;
    a_nx      = launch ? srcA : a;
    b_nx      = launch ? srcB : b;
    is_div_nx = launch ? is_div_op(mdOp) : is_div;
    is_sgn_nx = launch ? (mdOp == MD_MULT || mdOp == MD_DIV) : is_sgn;
    hi_nx     = wr_res ? res[63:32] : (state == IDLE && start && mdOp == MD_MTHI) ? srcA : hi;
    lo_nx     = wr_res ? res[31:0] : (state == IDLE && start && mdOp == MD_MTLO) ? srcA : lo;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      a      <= 32'd0;
      b      <= 32'd0;
      is_div <= 1'b0;
      is_sgn <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      a      <= a_nx;
      b      <= b_nx;
      is_div <= is_div_nx;
      is_sgn <= is_sgn_nx;
      hi     <= hi_nx;
      lo     <= lo_nx;
    end
  end
endmodule
